// File: rtl/sync_fifo_if.sv
// Handshake bundle between a single-clock FIFO and its user: write side, read side,
// occupancy/threshold status and sticky error flags.
interface sync_fifo_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 6
);
    logic             flush;
    logic             wreq;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             wfull_almst;
    logic             rreq;
    logic [DSIZE-1:0] rdata;
    logic             rdvld;
    logic             repty;
    logic             repty_almst;
    logic [ASIZE:0]   level;
    logic             ovf;
    logic             udf;

    modport master (
        output flush, wreq, wdata, rreq,
        input  wfull, wfull_almst, rdata, rdvld, repty, repty_almst, level, ovf, udf
    );

    modport slave (
        input  flush, wreq, wdata, rreq,
        output wfull, wfull_almst, rdata, rdvld, repty, repty_almst, level, ovf, udf
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// standard or first-word-fall-through reads, synchronous flush and sticky error flags.
module sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 6,
    parameter int ALMST = 12,
    parameter int FWFT  = 0
) (
    input logic        clk,
    input logic        rst_n,
    sync_fifo_if.slave fifo
);
    localparam int             DEPTH     = 2 ** ASIZE;
    localparam logic [ASIZE:0] ONE       = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] ALMST_LVL = ALMST[ASIZE:0];
    localparam logic [ASIZE:0] AFULL_LVL = DEPTH[ASIZE:0] - ALMST_LVL;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr, rptr, level_q;
    logic [ASIZE:0]   wptr_nxt, rptr_nxt, level_nxt;
    logic             wfull_q, wfull_almst_q, repty_q, repty_almst_q;
    logic             ovf_q, udf_q;
    logic             wr_en, rd_en;

    // Acceptance uses this cycle's registered flags; flush overrides both requests.
    assign wr_en = fifo.wreq & ~wfull_q & ~fifo.flush;
    assign rd_en = fifo.rreq & ~repty_q & ~fifo.flush;

    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        level_nxt = level_q;
        if (fifo.flush) begin
            wptr_nxt  = '0;
            rptr_nxt  = '0;
            level_nxt = '0;
        end else begin
            if (wr_en) wptr_nxt = wptr + ONE;
            if (rd_en) rptr_nxt = rptr + ONE;
            if (wr_en && !rd_en)      level_nxt = level_q + ONE;
            else if (rd_en && !wr_en) level_nxt = level_q - ONE;
        end
    end

    // Flags are computed from next-state pointers/level so they are exact right after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            level_q       <= '0;
            wfull_q       <= 1'b0;
            wfull_almst_q <= 1'b0;
            repty_q       <= 1'b1;
            repty_almst_q <= 1'b1;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
        end else begin
            wptr          <= wptr_nxt;
            rptr          <= rptr_nxt;
            level_q       <= level_nxt;
            wfull_q       <= (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]) &&
                             (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]);
            repty_q       <= (wptr_nxt == rptr_nxt);
            wfull_almst_q <= (level_nxt >= AFULL_LVL);
            repty_almst_q <= (level_nxt <= ALMST_LVL);
            if (fifo.flush) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                if (fifo.wreq && wfull_q) ovf_q <= 1'b1;
                if (fifo.rreq && repty_q) udf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[ASIZE-1:0]] <= fifo.wdata;
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DSIZE-1:0] rdata_q;
            logic             rdvld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    rdvld_q <= 1'b0;
                end else begin
                    rdvld_q <= rd_en;
                    if (rd_en) rdata_q <= mem[rptr[ASIZE-1:0]];
                end
            end

            assign fifo.rdata = rdata_q;
            assign fifo.rdvld = rdvld_q;
        end else begin : g_fwft_read
            // Head word is always presented; the memory write lands on the same edge repty falls.
            assign fifo.rdata = mem[rptr[ASIZE-1:0]];
            assign fifo.rdvld = ~repty_q;
        end
    endgenerate

    assign fifo.wfull       = wfull_q;
    assign fifo.wfull_almst = wfull_almst_q;
    assign fifo.repty       = repty_q;
    assign fifo.repty_almst = repty_almst_q;
    assign fifo.level       = level_q;
    assign fifo.ovf         = ovf_q;
    assign fifo.udf         = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo: a standard-read and an FWFT instance
// share one stimulus stream and are both compared against a queue-based model.
module tb_sync_fifo;
    localparam int DEPTH = 64;
    localparam int ALMST = 12;

    logic clk;
    logic rst_n;

    sync_fifo_if #(.DSIZE(8), .ASIZE(6)) f0 ();
    sync_fifo_if #(.DSIZE(8), .ASIZE(6)) f1 ();

    sync_fifo #(.DSIZE(8), .ASIZE(6), .ALMST(ALMST), .FWFT(0)) dut_std (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (f0)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(6), .ALMST(ALMST), .FWFT(1)) dut_fwft (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (f1)
    );

    assign f1.flush = f0.flush;
    assign f1.wreq  = f0.wreq;
    assign f1.wdata = f0.wdata;
    assign f1.rreq  = f0.rreq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_udf;
    bit         exp_rdvld0;
    int         tests_run;
    int         tests_failed;

    task automatic check_output(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from the pre-edge occupancy.
    task automatic apply_stimulus(input bit w, input logic [7:0] d, input bit r, input bit f);
        bit full, empty, wa, ra;
        f0.wreq  = w;
        f0.wdata = d;
        f0.rreq  = r;
        f0.flush = f;
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        wa    = w && !full;
        ra    = r && !empty;
        @(posedge clk);
        if (f) begin
            model_q.delete();
            m_ovf      = 0;
            m_udf      = 0;
            exp_rdvld0 = 0;
        end else begin
            if (w && full)  m_ovf = 1;
            if (r && empty) m_udf = 1;
            if (ra) exp_q.push_back(model_q.pop_front());
            if (wa) model_q.push_back(d);
            exp_rdvld0 = ra;
        end
        #1;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard whenever rdata is valid.
    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        check_output("level",       int'(f0.level),       sz);
        check_output("repty",       int'(f0.repty),       int'(sz == 0));
        check_output("repty_almst", int'(f0.repty_almst), int'(sz <= ALMST));
        check_output("wfull",       int'(f0.wfull),       int'(sz == DEPTH));
        check_output("wfull_almst", int'(f0.wfull_almst), int'(sz >= DEPTH - ALMST));
        check_output("ovf",         int'(f0.ovf),         int'(m_ovf));
        check_output("udf",         int'(f0.udf),         int'(m_udf));
        check_output("rdvld",       int'(f0.rdvld),       int'(exp_rdvld0));
        if (f0.rdvld) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL rdata_unexpected: got %0d expected no valid data at %0t",
                         f0.rdata, $time);
            end else begin
                check_output("rdata", int'(f0.rdata), int'(exp_q.pop_front()));
            end
        end
        check_output("fwft_level", int'(f1.level), sz);
        check_output("fwft_rdvld", int'(f1.rdvld), int'(sz != 0));
        check_output("fwft_ovf",   int'(f1.ovf),   int'(m_ovf));
        check_output("fwft_udf",   int'(f1.udf),   int'(m_udf));
        if (sz != 0) check_output("fwft_rdata", int'(f1.rdata), int'(model_q[0]));
    end

    initial begin
        int wp;
        int rp;
        tests_run    = 0;
        tests_failed = 0;
        m_ovf        = 0;
        m_udf        = 0;
        exp_rdvld0   = 0;
        rst_n    = 1'b0;
        f0.flush = 1'b0;
        f0.wreq  = 1'b0;
        f0.wdata = 8'h00;
        f0.rreq  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (10) apply_stimulus(0, 8'h00, 0, 0);

        // Fill to full, overflow attempt, drain, underflow attempt.
        for (int i = 1; i <= 64; i++) apply_stimulus(1, 8'(i), 0, 0);
        apply_stimulus(1, 8'h41, 0, 0);
        for (int i = 0; i < 64; i++) apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        apply_stimulus(0, 8'h00, 0, 1);

        // Simultaneous write+read at full, then long streaming at level 1.
        for (int i = 1; i <= 64; i++) apply_stimulus(1, 8'(i), 0, 0);
        apply_stimulus(1, 8'hEE, 1, 0);
        apply_stimulus(0, 8'h00, 0, 1);
        apply_stimulus(1, 8'h80, 0, 0);
        for (int i = 0; i < 200; i++) apply_stimulus(1, 8'($urandom), 1, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 0, 0);

        // FWFT visibility latency and pop-to-next-word.
        apply_stimulus(1, 8'hA5, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        apply_stimulus(1, 8'h5A, 0, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 0, 0);

        // Flush has priority over a concurrent write.
        for (int i = 0; i < 30; i++) apply_stimulus(1, 8'($urandom), 0, 0);
        apply_stimulus(1, 8'hFF, 0, 1);
        apply_stimulus(1, 8'h11, 0, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 0, 0);

        // Async reset mid-burst at level 40, after setting udf.
        apply_stimulus(0, 8'h00, 1, 0);
        for (int i = 0; i < 40; i++) apply_stimulus(1, 8'($urandom), 0, 0);
        #1 rst_n = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_ovf      = 0;
        m_udf      = 0;
        exp_rdvld0 = 0;
        #1;
        check_output("rst_level",       int'(f0.level),       0);
        check_output("rst_repty",       int'(f0.repty),       1);
        check_output("rst_repty_almst", int'(f0.repty_almst), 1);
        check_output("rst_udf",         int'(f0.udf),         0);
        check_output("rst_fwft_rdvld",  int'(f1.rdvld),       0);
        apply_stimulus(0, 8'h00, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        apply_stimulus(1, 8'h07, 0, 0);
        apply_stimulus(0, 8'h00, 1, 0);
        apply_stimulus(0, 8'h00, 0, 0);

        // Random traffic with varying write/read bias and occasional flush.
        for (int blk = 0; blk < 6; blk++) begin
            wp = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 25 : 55);
            rp = 100 - wp;
            for (int i = 0; i < 400; i++) begin
                apply_stimulus($urandom_range(0, 99) < wp, 8'($urandom),
                               $urandom_range(0, 99) < rp, $urandom_range(0, 299) == 0);
            end
        end

        apply_stimulus(0, 8'h00, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
